// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle adder/subtractor, DIGIT bits per clock,
// LSB slice first, with registered carry and start/busy/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [WIDTH-1:0]       r_sh;
    logic                   carry;
    logic [CW-1:0]          cnt;

    logic [DIGIT:0]         sl;
    logic [WIDTH+DIGIT-1:0] r_nxt;
    logic                   c_msb;
    logic                   last;

    // Carry into the slice's top bit recovered from its sum bit and operands;
    // for DIGIT=1 this is simply the carry register.
    always_comb begin
        sl    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
        c_msb = sl[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];
        r_nxt = {sl[DIGIT-1:0], r_sh};
        last  = (cnt == CW'(NSLICE - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b ^ {WIDTH{mode}};
                        carry <= cin ^ mode;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    r_sh  <= r_nxt[WIDTH+DIGIT-1:DIGIT];
                    carry <= sl[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum   <= r_nxt[WIDTH+DIGIT-1:DIGIT];
                        cout  <= sl[DIGIT];
                        ovf   <= sl[DIGIT] ^ c_msb;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for two serial_add_sub instances
// (8-bit/1-bit digit and 16-bit/4-bit digit).
module tb_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst8, rst16;
    logic        start8, mode8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        start16, mode16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int total = 0;
    int bad   = 0;
    int nd8   = 0;
    int nd16  = 0;
    logic [17:0] q8[$];
    logic [17:0] q16[$];

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst8), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst16), .start(start16), .mode(mode16),
        .a(a16), .b(b16), .cin(cin16), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum}; overflow from operand/result sign bits.
    function automatic logic [17:0] model(input int w, input logic m,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci);
        logic [31:0] mask, xx, bb, full, s;
        logic co, ov;
        mask = (32'd1 << w) - 32'd1;
        xx   = {16'h0, x} & mask;
        bb   = (m ? ~{16'h0, y} : {16'h0, y}) & mask;
        full = xx + bb + {31'd0, ci ^ m};
        s    = full & mask;
        co   = full[w];
        ov   = (xx[w-1] == bb[w-1]) && (s[w-1] != xx[w-1]);
        return {ov, co, s[15:0]};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            nd8++;
            if (q8.size() == 0) chk("sb8_empty", 1, 0);
            else begin
                logic [17:0] e;
                e = q8.pop_front();
                chk("sum8", {24'h0, sum8}, {24'h0, e[7:0]});
                chk("cout8", {31'h0, cout8}, {31'h0, e[16]});
                chk("ovf8", {31'h0, ovf8}, {31'h0, e[17]});
            end
        end
        if (done16) begin
            nd16++;
            if (q16.size() == 0) chk("sb16_empty", 1, 0);
            else begin
                logic [17:0] e;
                e = q16.pop_front();
                chk("sum16", {16'h0, sum16}, {16'h0, e[15:0]});
                chk("cout16", {31'h0, cout16}, {31'h0, e[16]});
                chk("ovf16", {31'h0, ovf16}, {31'h0, e[17]});
            end
        end
    end

    task automatic run_op(input int u, input logic m, input logic [15:0] x,
                          input logic [15:0] y, input logic ci,
                          input bit poke);
        int k, nb, ns;
        bit seen, dn, bz;
        logic [15:0] prev;
        ns = (u == 0) ? 8 : 4;
        @(negedge clk);
        k = 0;
        while (k < 50 && (u == 0 ? (busy8 || done8) : (busy16 || done16))) begin
            @(negedge clk);
            k++;
        end
        prev = (u == 0) ? {8'h0, sum8} : sum16;
        if (u == 0) begin
            start8 = 1'b1; mode8 = m; a8 = x[7:0]; b8 = y[7:0]; cin8 = ci;
            q8.push_back(model(8, m, x, y, ci));
        end else begin
            start16 = 1'b1; mode16 = m; a16 = x; b16 = y; cin16 = ci;
            q16.push_back(model(16, m, x, y, ci));
        end
        @(posedge clk);
        #1;
        if (u == 0) begin
            start8 = 1'b0; mode8 = 1'($urandom); cin8 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
        end else begin
            start16 = 1'b0; mode16 = 1'($urandom); cin16 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
        end
        k = 0; nb = 0; seen = 0;
        while (k < 60 && !seen) begin
            @(negedge clk);
            k++;
            if (u == 0) begin
                start8 = poke && (k == 3 || k == 5);
                if (start8) begin
                    a8 = 8'($urandom); b8 = 8'($urandom); mode8 = 1'($urandom);
                end
            end
            bz = (u == 0) ? busy8 : busy16;
            dn = (u == 0) ? done8 : done16;
            if (k == 2)
                chk("sum_stable", (u == 0) ? {24'h0, sum8} : {16'h0, sum16},
                    {16'h0, prev});
            if (bz) nb++;
            if (dn) seen = 1;
        end
        chk("done_seen", {31'h0, seen}, 1);
        chk("latency", k - 1, ns);
        chk("busy_cycles", nb, ns);
        @(negedge clk);
        chk("done_pulse", (u == 0) ? {31'h0, done8} : {31'h0, done16}, 0);
    endtask

    initial begin
        int nd;
        rst8 = 1'b1; rst16 = 1'b1;
        start8 = 0; mode8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        start16 = 0; mode16 = 0; cin16 = 0; a16 = 0; b16 = 0;
        #3;
        chk("rst_busy", {31'h0, busy8}, 0);
        chk("rst_done", {31'h0, done8}, 0);
        chk("rst_sum", {24'h0, sum8}, 0);
        chk("rst_cout", {31'h0, cout8}, 0);
        chk("rst_ovf", {31'h0, ovf8}, 0);
        chk("rst_sum16", {16'h0, sum16}, 0);
        repeat (2) @(negedge clk);
        rst8 = 1'b0; rst16 = 1'b0;

        // First op also pokes start twice mid-RUN; those must be ignored.
        nd = nd8;
        run_op(0, 1'b0, 16'h5A, 16'h33, 1'b0, 1);
        repeat (5) @(negedge clk);
        chk("one_done", nd8 - nd, 1);
        chk("sum_hold", {24'h0, sum8}, 32'h8D);
        chk("plan_5a33", model(8, 0, 16'h5A, 16'h33, 0), {2'b10, 16'h8D});

        run_op(0, 1'b0, 16'hFF, 16'h00, 1'b1, 0);
        run_op(0, 1'b1, 16'h00, 16'h01, 1'b0, 0);
        run_op(0, 1'b1, 16'h10, 16'h01, 1'b1, 0);
        run_op(0, 1'b1, 16'h80, 16'h01, 1'b0, 0);

        // Abort mid-RUN with an asynchronous reset.
        @(negedge clk);
        start8 = 1'b1; mode8 = 0; a8 = 8'h11; b8 = 8'h22; cin8 = 0;
        q8.push_back(model(8, 0, 16'h11, 16'h22, 0));
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst8 = 1'b1;
        #1;
        chk("abort_busy", {31'h0, busy8}, 0);
        chk("abort_done", {31'h0, done8}, 0);
        chk("abort_sum", {24'h0, sum8}, 0);
        chk("abort_cout", {31'h0, cout8}, 0);
        chk("abort_ovf", {31'h0, ovf8}, 0);
        q8.delete();
        nd = nd8;
        @(negedge clk);
        rst8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_nodone", nd8 - nd, 0);
        run_op(0, 1'b0, 16'h3C, 16'h4B, 1'b1, 0);

        run_op(1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(1, 1'b1, 16'h8000, 16'h0001, 1'b0, 0);
        run_op(1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0);

        for (int i = 0; i < 20; i++) begin
            run_op(0, 1'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 0);
            run_op(1, 1'($urandom), 16'($urandom), 16'($urandom),
                   1'($urandom), 0);
        end

        repeat (4) @(negedge clk);
        chk("drain8", q8.size(), 0);
        chk("drain16", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
